// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to renderers and the VGA pins.
// master drives the coordinates, syncs and strobes; slave consumes them.
interface vga_timing_gen_if;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        frame_start;
    logic        line_end;
    logic [15:0] frame_count;

    modport master (
        output DrawX, DrawY, hs, vs, blank, frame_start, line_end, frame_count
    );

    modport slave (
        input  DrawX, DrawY, hs, vs, blank, frame_start, line_end, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel/line counters, active-low syncs, active-video flag, frame/line strobes and frame counter.
// Every output is registered from next-state counter values, so coordinates and flags describe the same pixel; no backpressure.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic              vga_clk,
    input  logic              reset,
    vga_timing_gen_if.master  vga
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]  r_hcount;
    logic [9:0]  r_vcount;
    logic        r_hs;
    logic        r_vs;
    logic        r_blank;
    logic        r_frame_start;
    logic        r_line_end;
    logic [15:0] r_frame_count;

    logic        w_h_wrap;
    logic        w_frame_wrap;
    logic [9:0]  w_hcount_nxt;
    logic [9:0]  w_vcount_nxt;
    logic        w_hs_nxt;
    logic        w_vs_nxt;
    logic        w_blank_nxt;
    logic        w_line_end_nxt;

    // Flags are decoded from the counter values about to be loaded, keeping them aligned with DrawX/DrawY.
    always_comb begin
        w_h_wrap       = (r_hcount == H_LAST);
        w_frame_wrap   = w_h_wrap && (r_vcount == V_LAST);
        w_hcount_nxt   = w_h_wrap ? 10'd0 : r_hcount + 10'd1;
        w_vcount_nxt   = r_vcount;
        if (w_frame_wrap) begin
            w_vcount_nxt = 10'd0;
        end else if (w_h_wrap) begin
            w_vcount_nxt = r_vcount + 10'd1;
        end
        w_hs_nxt       = !((w_hcount_nxt >= HS_START) && (w_hcount_nxt < HS_END));
        w_vs_nxt       = !((w_vcount_nxt >= VS_START) && (w_vcount_nxt < VS_END));
        w_blank_nxt    = (w_hcount_nxt < H_ACT) && (w_vcount_nxt < V_ACT);
        w_line_end_nxt = (w_hcount_nxt == H_LAST);
    end

    // Reset parks the counters on the last pixel so the first clock after release starts frame 0.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_hcount      <= H_LAST;
            r_vcount      <= V_LAST;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_blank       <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_end    <= 1'b0;
            r_frame_count <= 16'hFFFF;
        end else begin
            r_hcount      <= w_hcount_nxt;
            r_vcount      <= w_vcount_nxt;
            r_hs          <= w_hs_nxt;
            r_vs          <= w_vs_nxt;
            r_blank       <= w_blank_nxt;
            r_frame_start <= w_frame_wrap;
            r_line_end    <= w_line_end_nxt;
            if (w_frame_wrap) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    assign vga.DrawX       = r_hcount;
    assign vga.DrawY       = r_vcount;
    assign vga.hs          = r_hs;
    assign vga.vs          = r_vs;
    assign vga.blank       = r_blank;
    assign vga.frame_start = r_frame_start;
    assign vga.line_end    = r_line_end;
    assign vga.frame_count = r_frame_count;

endmodule
